in_port_ctrl: RTL and testbench
===============================

# in_port_ctrl

Switch-input controller between the board slide switches and the single-cycle CPU's `in_port0`/`in_port1` inputs. It synchronises SW9..SW0, debounces each 5-bit switch group independently, and publishes stable zero-extended operands to the CPU. The published values change only when the CPU is not freezing them, and each change is flagged with a one-cycle pulse. It replaces the direct switch-to-port path in the top level; `in_port2` is not handled here.

## Interface
- `DEBOUNCE_CYCLES`, 4: cycles a synchronised group must hold a new value before acceptance; legal range ≥ 2.
- `PORT_W`, 32: width of the published ports.
- `clk`  in  1  system clock; the same `clk` that drives the CPU's memory clock domain.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clk`.
- `sw`  in  10  raw asynchronous switches; `sw[9:5]` is the high group (addend), `sw[4:0]` is the low group (augend).
- `freeze`  in  1  from the CPU I/O logic; while 1, the published ports hold their value.
- `in_port0`  out  PORT_W  `{27'b0, accepted sw[9:5]}`.
- `in_port1`  out  PORT_W  `{27'b0, accepted sw[4:0]}`.
- `changed`  out  1  one-cycle pulse after any published port changes.
- `changed_mask`  out  2  valid with `changed`: bit1 = `in_port0` changed, bit0 = `in_port1` changed.

## Operation
- **Synchroniser:** two flops (`s1`, `s2`) for all 10 bits; no logic between them.
- **Per-group debouncer:** registers `cand[4:0]`, `stable[4:0]`, a counter `cnt` of width clog2(DEBOUNCE_CYCLES), and a state.
  - **IDLE:**
    - `s2 == stable`: stay in IDLE.
    - otherwise: `cand <= s2`, `cnt <= 0`, go to SETTLING.
  - **SETTLING:**
    - `s2 == cand` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`, go to IDLE.
    - `s2 == cand` otherwise: `cnt <= cnt+1`.
    - `s2 != cand` and `s2 == stable`: glitch; go to IDLE with `stable` unchanged.
    - `s2 != cand` otherwise: `cand <= s2`, `cnt <= 0`, stay in SETTLING.
- **Publish registers:**
  - On each edge with `freeze == 0`: `pubN <= stableN`.
  - With `freeze == 1`: hold.
- **Change flag:**
  - On the same edge, `changed_mask` bits are set where `pubN` will differ from its new value.
  - `changed` is the OR of the `changed_mask` bits, registered so it aligns with the updated `in_port`.
  - When both groups change on the same edge, a single pulse is issued with `changed_mask = 2'b11`.
- **Width rule:** groups are unsigned 0..31, zero-extended to PORT_W; no decimal conversion here.

## Timing
- **Reset values:** `s1`, `s2`, `cand`, `stable`, `cnt` are 0; both states are IDLE; `in_port0`, `in_port1`, `changed`, `changed_mask` are 0.
- **Latency:** a group value first sampled into `s1` at edge k, and held, appears on `in_port` after edge k+DEBOUNCE_CYCLES+3. `changed` is high for exactly the cycle after that edge.
- **Glitches:** a glitch shorter than DEBOUNCE_CYCLES cycles at `s2` never reaches `stable`; no pulse.
- **Bouncing:** a bouncing input restarts the count on every new candidate. Acceptance requires DEBOUNCE_CYCLES consecutive equal `s2` samples after the candidate load.
- **Freeze:**
  - A `stable` update during `freeze = 1` is deferred.
  - The first edge sampling `freeze = 0` publishes the latest `stable`, with a pulse only if the value differs.
  - Intermediate values accepted during the freeze are never published.
- **Reset mid-settle:** the settle is aborted; after reset, switches still held high are re-debounced from zero and published with a pulse.
- **Groups:** the two groups are fully independent; simultaneous transitions in both groups are allowed.

## Structure
- **Shared package `io_ctrl_pkg`:**
  - `deb_state_t` enum {IDLE, SETTLING}.
  - `SW_GROUP_W = 5`.
  - `PORT_W_DEFAULT = 32`.
- **Sub-module `sw_debounce_group`:** parameter DEBOUNCE_CYCLES; ports `clk`, `reset`, `din[4:0]` (already synchronised), `stable[4:0]`. It is instantiated twice.
- **Top level:** the synchroniser, publish registers and change flag stay in `in_port_ctrl`. Target size is about 150–200 lines total.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Reset:** hold `reset` 3 cycles with `sw = 10'h3FF`.
  - Outputs are 0 during reset.
  - After release, `in_port0 = 31` and `in_port1 = 31` appear together 7 edges after the first sampling edge, with `changed = 1` and `changed_mask = 11` for one cycle.
- **Clean change:** `sw` 0 → `10'b00011_00101`, held.
  - `in_port0 = 3`, `in_port1 = 5` after edge k+7.
  - Single pulse with `changed_mask = 11`.
- **Glitch:** `sw[0]` high for 3 cycles, then low.
  - `in_port1` stays 0; `changed` is never asserted.
- **Bounce:** `sw[9:5]` toggles 1,0,1,0 every 2 cycles, then holds 1.
  - `in_port0 = 1` exactly 7 edges after the final transition is sampled.
  - One pulse, `changed_mask = 10`.
- **Freeze:** assert `freeze`, change `sw[4:0]` to 9 then to 12 (each held 10 cycles), release `freeze`.
  - `in_port1` holds the old value throughout.
  - On release it goes directly to 12 with one pulse; 9 is never observed.
- **Reset mid-settle:** `reset` asserted 2 cycles after `sw` changes to `10'h021`.
  - Outputs return to 0.
  - After release, `in_port0 = 1`, `in_port1 = 1` are published with one pulse at the full latency.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the switch-input controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   deb_state_t    - debouncer state (IDLE / SETTLING)
//   SW_GROUP_W     - width of one slide-switch group
//   PORT_W_DEFAULT - default width of the CPU input ports
package io_ctrl_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

  localparam int SW_GROUP_W     = 5;
  localparam int PORT_W_DEFAULT = 32;

endpackage : io_ctrl_pkg

// File: rtl/sw_debounce_group.sv
// Debounces one already-synchronised 5-bit switch group.
// Latency: a new value held at din is accepted into stable DEBOUNCE_CYCLES+1 edges after din first shows it.
// Backpressure: none; free-running, always accepts input.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   din        - synchronised switch group
//   stable     - last value that held for DEBOUNCE_CYCLES consecutive samples
// DEBOUNCE_CYCLES must be at least 2.
module sw_debounce_group
  import io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW_GROUP_W-1:0] din,
  output logic [SW_GROUP_W-1:0] stable
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  deb_state_t            state_q,  state_d;
  logic [SW_GROUP_W-1:0] cand_q,   cand_d;
  logic [SW_GROUP_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (din != stable_q) begin
          cand_d  = din;
          cnt_d   = '0;
          state_d = SETTLING;
        end
      end

      SETTLING: begin
        if (din == cand_q) begin
          // The load cycle is not counted; CNT_LAST is reached after
          // DEBOUNCE_CYCLES equal samples following the load.
          if (cnt_q == CNT_LAST) begin
            stable_d = cand_q;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (din == stable_q) begin
          // Input fell back to the accepted value: treat as a glitch.
          state_d = IDLE;
        end else begin
          // A different new value: restart the count on it.
          cand_d = din;
          cnt_d  = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule : sw_debounce_group

// File: rtl/in_port_ctrl.sv
// Slide-switch front end for the CPU: synchronise, debounce per group, publish zero-extended operands.
// Latency: a held switch value sampled at edge k appears on in_port after edge k+DEBOUNCE_CYCLES+3.
// Backpressure: freeze=1 holds the published ports; updates are deferred, not queued.
//
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   sw[9:0]       - raw asynchronous switches; [9:5] high group, [4:0] low group
//   freeze        - hold published ports while high
//   in_port0      - zero-extended accepted sw[9:5]
//   in_port1      - zero-extended accepted sw[4:0]
//   changed       - one-cycle pulse in the cycle after a published port changes
//   changed_mask  - valid with changed: bit1 = in_port0 changed, bit0 = in_port1 changed
// PORT_W must be greater than SW_GROUP_W.
module in_port_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PORT_W          = PORT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        sw,
  input  logic              freeze,
  output logic [PORT_W-1:0] in_port0,
  output logic [PORT_W-1:0] in_port1,
  output logic              changed,
  output logic [1:0]        changed_mask
);

  localparam int PAD_W = PORT_W - SW_GROUP_W;

  // Two-flop synchroniser across all switch bits.
  logic [9:0] s1_q, s1_d;
  logic [9:0] s2_q, s2_d;

  // Debounced group values.
  logic [SW_GROUP_W-1:0] stable0;
  logic [SW_GROUP_W-1:0] stable1;

  // Published values and change flag.
  logic [SW_GROUP_W-1:0] pub0_q, pub0_d;
  logic [SW_GROUP_W-1:0] pub1_q, pub1_d;
  logic                  changed_q, changed_d;
  logic [1:0]            changed_mask_q, changed_mask_d;

  sw_debounce_group #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_hi (
    .clk   (clk),
    .reset (reset),
    .din   (s2_q[9:5]),
    .stable(stable0)
  );

  sw_debounce_group #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_lo (
    .clk   (clk),
    .reset (reset),
    .din   (s2_q[4:0]),
    .stable(stable1)
  );

  always_comb begin
    s1_d = sw;
    s2_d = s1_q;

    pub0_d = pub0_q;
    pub1_d = pub1_q;
    if (!freeze) begin
      pub0_d = stable0;
      pub1_d = stable1;
    end

    // Flag is registered alongside the publish registers, so the pulse
    // lines up with the first cycle the new value is visible.
    changed_mask_d = {pub0_d != pub0_q, pub1_d != pub1_q};
    changed_d      = |changed_mask_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q           <= '0;
      s2_q           <= '0;
      pub0_q         <= '0;
      pub1_q         <= '0;
      changed_q      <= 1'b0;
      changed_mask_q <= '0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      pub0_q         <= pub0_d;
      pub1_q         <= pub1_d;
      changed_q      <= changed_d;
      changed_mask_q <= changed_mask_d;
    end
  end

  assign in_port0     = {{PAD_W{1'b0}}, pub0_q};
  assign in_port1     = {{PAD_W{1'b0}}, pub1_q};
  assign changed      = changed_q;
  assign changed_mask = changed_mask_q;

endmodule : in_port_ctrl

// File: tb/tb_in_port_ctrl.sv
// Directed bench for in_port_ctrl with DEBOUNCE_CYCLES = 4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-derived: k+7 edge latency from first s1 sample.
module tb_in_port_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  sw;
  logic        freeze;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        changed;
  logic [1:0]  changed_mask;

  int total = 0;
  int bad   = 0;

  in_port_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .PORT_W         (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw          (sw),
    .freeze      (freeze),
    .in_port0    (in_port0),
    .in_port1    (in_port1),
    .changed     (changed),
    .changed_mask(changed_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                         input logic ch, input logic [1:0] mask);
    chk({tag, ".in_port0"}, in_port0, p0);
    chk({tag, ".in_port1"}, in_port1, p1);
    chk({tag, ".changed"}, 32'(changed), 32'(ch));
    chk({tag, ".mask"}, 32'(changed_mask), 32'(mask));
  endtask

  // Called right after sw was changed. Ports hold the old values through
  // edge k+6, update with a pulse at k+7, and the pulse is gone at k+8.
  task automatic run_latency(input string tag, input logic [31:0] n0, input logic [31:0] n1,
                             input logic [1:0] mask, input logic [31:0] o0, input logic [31:0] o1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk_all({tag, ".wait"}, o0, o1, 1'b0, 2'b00);
    end
    step();
    chk_all({tag, ".pub"}, n0, n1, 1'b1, mask);
    step();
    chk_all({tag, ".after"}, n0, n1, 1'b0, 2'b00);
  endtask

  initial begin
    // Reset with all switches high.
    reset  = 1'b1;
    freeze = 1'b0;
    sw     = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("reset", 0, 0, 1'b0, 2'b00);
    end
    reset = 1'b0;
    run_latency("rst_release", 31, 31, 2'b11, 0, 0);

    // Back to zero, then a clean change in both groups.
    sw = 10'h000;
    run_latency("to_zero", 0, 0, 2'b11, 31, 31);
    sw = 10'b00011_00101;
    run_latency("clean", 3, 5, 2'b11, 0, 0);

    // Return to zero before the glitch test.
    sw = 10'h000;
    run_latency("zero2", 0, 0, 2'b11, 3, 5);

    // Three-cycle glitch on sw[0] must never be published.
    sw = 10'h001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("glitch_hi", 0, 0, 1'b0, 2'b00);
    end
    sw = 10'h000;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_all("glitch_lo", 0, 0, 1'b0, 2'b00);
    end

    // High group bounces 1,0,1,0 every two cycles, then holds 1.
    for (int r = 0; r < 2; r++) begin
      sw = {5'd1, 5'd0};
      step();
      chk_all("bounce1", 0, 0, 1'b0, 2'b00);
      step();
      chk_all("bounce1", 0, 0, 1'b0, 2'b00);
      sw = 10'h000;
      step();
      chk_all("bounce0", 0, 0, 1'b0, 2'b00);
      step();
      chk_all("bounce0", 0, 0, 1'b0, 2'b00);
    end
    sw = {5'd1, 5'd0};
    run_latency("bounce", 1, 0, 2'b10, 0, 0);

    // Freeze: low group goes to 9 then 12 while frozen; only 12 is published.
    freeze = 1'b1;
    sw     = {5'd1, 5'd9};
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("frz9", 1, 0, 1'b0, 2'b00);
    end
    sw = {5'd1, 5'd12};
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("frz12", 1, 0, 1'b0, 2'b00);
    end
    freeze = 1'b0;
    step();
    chk_all("unfreeze", 1, 12, 1'b1, 2'b01);
    step();
    chk_all("unfreeze_after", 1, 12, 1'b0, 2'b00);

    // Reset two cycles into a settle; switches stay at 10'h021.
    sw = 10'h021;
    step();
    step();
    reset = 1'b1;
    step();
    chk_all("mid_reset", 0, 0, 1'b0, 2'b00);
    step();
    chk_all("mid_reset", 0, 0, 1'b0, 2'b00);
    reset = 1'b0;
    run_latency("post_reset", 1, 1, 2'b11, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_in_port_ctrl
